// File: rtl/hls_pkg.sv
// hls_pkg: shared types, constants and helpers for HLS datapath blocks.
//   PIPE_STAGES : depth of the circuit_2 pipeline
//   CMP_WIDTH   : widest operand cmp_lt can handle (callers left-align into it)
//   stage_ctl_t : per-stage handshake bundle (upstream valid, own ready)
//   cmp_lt      : signed/unsigned less-than shared with other compare blocks
package hls_pkg;

    localparam int PIPE_STAGES = 3;
    localparam int CMP_WIDTH   = 64;

    typedef struct packed {
        logic valid;
        logic ready;
    } stage_ctl_t;

    // Operands are expected left-aligned in CMP_WIDTH bits (zeros below).
    // This keeps both the signed and the unsigned ordering of the narrower
    // value intact without needing to know its width here.
    function automatic logic cmp_lt(
        input logic [CMP_WIDTH-1:0] a,
        input logic [CMP_WIDTH-1:0] b,
        input logic                 signed_mode
    );
        if (signed_mode) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/data register slice of a valid/ready pipeline.
//   clk, rst  : clock, synchronous active-high reset (clears valid and data)
//   ctl       : upstream valid and this stage's ready (load enable)
//   up_data   : data offered by the upstream side
//   valid     : this stage holds a live item
//   data      : registered payload
module pipe_stage
    import hls_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  stage_ctl_t       ctl,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Loading on ready regardless of upstream valid lets empty slots pick up
    // junk data; that is harmless because valid follows the upstream valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ctl.ready) begin
            valid <= ctl.valid;
            data  <= up_data;
        end
    end

endmodule

// File: rtl/circuit_2_pipe.sv
// circuit_2_pipe: 3-stage valid/ready pipelined add/sub/compare/mux/shift.
//   Clk, Rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : input handshake for the a/b/c triple
//   a, b, c             : operands (DATAWIDTH bits)
//   out_valid, out_ready: output handshake for the x/z pair
//   x, z                : results, driven straight from stage-3 registers
// Stage 1 holds d/e/f, stage 2 holds lt/eq/g/h, stage 3 holds x/z.
// DATAWIDTH is limited to hls_pkg::CMP_WIDTH by the shared comparator.
module circuit_2_pipe
    import hls_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int SIGNED    = 0,
    parameter int SHAMT     = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z
);

    localparam int W1    = 3 * DATAWIDTH;
    localparam int W2    = 2 * DATAWIDTH + 2;
    localparam int W3    = 2 * DATAWIDTH;
    localparam int ALIGN = CMP_WIDTH - DATAWIDTH;

    logic v1, v2, v3;
    logic [PIPE_STAGES-1:0] vld;
    logic rdy1, rdy2, rdy3;
    stage_ctl_t s1_ctl, s2_ctl, s3_ctl;

    logic [W1-1:0] s1_in, s1_q;
    logic [W2-1:0] s2_in, s2_q;
    logic [W3-1:0] s3_in, s3_q;

    logic [DATAWIDTH-1:0] d_n, e_n, f_n;
    logic [DATAWIDTH-1:0] d1, e1, f1;
    logic [DATAWIDTH-1:0] g_n, h_n;
    logic                 lt_n, eq_n;
    logic [CMP_WIDTH-1:0] d_al, e_al;
    logic [DATAWIDTH-1:0] g2, h2;
    logic                 lt2, eq2;
    logic [DATAWIDTH-1:0] x_n, z_n;

    // Ready chain: a stage can load if it is empty or its successor can.
    // This is what squeezes bubbles out while the output is stalled.
    assign vld  = {v3, v2, v1};
    assign rdy3 = !vld[2] || out_ready;
    assign rdy2 = !vld[1] || rdy3;
    assign rdy1 = !vld[0] || rdy2;

    assign s1_ctl = '{valid: in_valid, ready: rdy1};
    assign s2_ctl = '{valid: v1,       ready: rdy2};
    assign s3_ctl = '{valid: v2,       ready: rdy3};

    assign in_ready  = rdy1;
    assign out_valid = vld[PIPE_STAGES-1];

    // Stage 1 inputs: sums and difference, carries and borrows discarded.
    always_comb begin
        d_n   = a + b;
        e_n   = a + c;
        f_n   = a - b;
        s1_in = {d_n, e_n, f_n};
    end

    assign {d1, e1, f1} = s1_q;

    // Stage 2 inputs: compare and select.
    always_comb begin
        d_al  = CMP_WIDTH'(d1) << ALIGN;
        e_al  = CMP_WIDTH'(e1) << ALIGN;
        lt_n  = cmp_lt(d_al, e_al, SIGNED != 0);
        eq_n  = (d1 == e1);
        g_n   = lt_n ? e1 : d1;
        h_n   = eq_n ? f1 : g_n;
        s2_in = {lt_n, eq_n, g_n, h_n};
    end

    assign {lt2, eq2, g2, h2} = s2_q;

    // Stage 3 inputs: conditional logical shifts.
    always_comb begin
        x_n   = lt2 ? (g2 << SHAMT) : g2;
        z_n   = eq2 ? (h2 >> SHAMT) : h2;
        s3_in = {x_n, z_n};
    end

    assign x = s3_q[W3-1:DATAWIDTH];
    assign z = s3_q[DATAWIDTH-1:0];

    pipe_stage #(.WIDTH(W1)) u_s1 (
        .clk     (Clk),
        .rst     (Rst),
        .ctl     (s1_ctl),
        .up_data (s1_in),
        .valid   (v1),
        .data    (s1_q)
    );

    pipe_stage #(.WIDTH(W2)) u_s2 (
        .clk     (Clk),
        .rst     (Rst),
        .ctl     (s2_ctl),
        .up_data (s2_in),
        .valid   (v2),
        .data    (s2_q)
    );

    pipe_stage #(.WIDTH(W3)) u_s3 (
        .clk     (Clk),
        .rst     (Rst),
        .ctl     (s3_ctl),
        .up_data (s3_in),
        .valid   (v3),
        .data    (s3_q)
    );

endmodule

// File: tb/tb_circuit_2_pipe.sv
// tb_circuit_2_pipe: self-checking bench for circuit_2_pipe.
// Two DUTs share stimulus: one unsigned-compare, one signed-compare.
// The reference is a FIFO of expected results pushed on input transfer and
// popped on output transfer; occupancy of that FIFO also predicts in_ready.
module tb_circuit_2_pipe;

    typedef struct packed {
        logic [31:0] xu;
        logic [31:0] zu;
        logic [31:0] xs;
        logic [31:0] zs;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0, b = '0, c = '0;
    logic        in_ready_u, out_valid_u, in_ready_s, out_valid_s;
    logic [31:0] xu, zu, xs, zs;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    logic prev_stall = 1'b0;
    logic [31:0] prev_x = '0, prev_z = '0;
    logic seen_ov = 1'b0;

    always #5 Clk = ~Clk;

    circuit_2_pipe #(.DATAWIDTH(32), .SIGNED(0), .SHAMT(1)) dut_u (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a), .b(b), .c(c), .out_valid(out_valid_u), .out_ready(out_ready),
        .x(xu), .z(zu)
    );

    circuit_2_pipe #(.DATAWIDTH(32), .SIGNED(1), .SHAMT(1)) dut_s (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .c(c), .out_valid(out_valid_s), .out_ready(out_ready),
        .x(xs), .z(zs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic statement of the dataflow, by case rather than by mux chain.
    function automatic exp_t model(input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] rc);
        logic [31:0] d, e, f;
        exp_t r;
        d = ra + rb;
        e = ra + rc;
        f = ra - rb;
        if (d == e) begin
            r.xu = d;      r.zu = f >> 1;
            r.xs = d;      r.zs = f >> 1;
        end else begin
            if (d < e) begin r.xu = e << 1; r.zu = e; end
            else       begin r.xu = d;      r.zu = d; end
            if ($signed(d) < $signed(e)) begin r.xs = e << 1; r.zs = e; end
            else                         begin r.xs = d;      r.zs = d; end
        end
        return r;
    endfunction

    // One cycle: called just after a falling edge, drives inputs, checks the
    // registered outputs, updates the reference, then advances to the next
    // falling edge.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ic, input logic ordy, input bit known,
                        input exp_t kexp, output bit acc);
        exp_t e;
        logic exp_ir;
        in_valid  = iv;
        a = ia; b = ib; c = ic;
        out_ready = ordy;
        #1;
        exp_ir = (q.size() < 3) || ordy;
        chk("in_ready", in_ready_u, exp_ir);
        chk("in_ready_s", in_ready_s, exp_ir);
        if (prev_stall) begin
            chk("stall_valid", out_valid_u, 1'b1);
            chk("stall_x", xu, prev_x);
            chk("stall_z", zu, prev_z);
        end
        if (out_valid_u && q.size() == 0) chk("stale_valid", out_valid_u, 1'b0);
        if (out_valid_u && ordy && q.size() > 0) begin
            e = q.pop_front();
            chk("x_unsigned", xu, e.xu);
            chk("z_unsigned", zu, e.zu);
            chk("valid_signed", out_valid_s, 1'b1);
            chk("x_signed", xs, e.xs);
            chk("z_signed", zs, e.zs);
        end
        acc = iv && in_ready_u;
        if (acc) q.push_back(known ? kexp : model(ia, ib, ic));
        prev_stall = out_valid_u && !ordy;
        prev_x = xu;
        prev_z = zu;
        seen_ov = out_valid_u;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle(input logic ordy);
        bit acc;
        step(1'b0, $urandom, $urandom, $urandom, ordy, 1'b0, '0, acc);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (q.size() > 0 && guard < 50) begin
            idle(1'b1);
            guard++;
        end
        chk(tag, q.size(), 0);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        in_valid = 1'b1;
        a = 32'd5; b = 32'd3; c = 32'd10;
        out_ready = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        prev_stall = 1'b0;
        #1;
        chk("rst_out_valid", out_valid_u, 1'b0);
        chk("rst_x", xu, 32'd0);
        chk("rst_z", zu, 32'd0);
        chk("rst_in_ready", in_ready_u, 1'b1);
        chk("rst_out_valid_s", out_valid_s, 1'b0);
        chk("rst_xs", xs, 32'd0);
    endtask

    task automatic send_known(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic,
                              input exp_t kexp);
        bit acc;
        step(1'b1, ia, ib, ic, 1'b1, 1'b1, kexp, acc);
        chk("known_accept", acc, 1'b1);
        drain("known_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   acc;
        int   lat;
        int   n_acc;
        int   sent;
        logic [31:0] bp_a[5], bp_b[5], bp_c[5];
        logic [31:0] ra, rb, rc;

        @(negedge Clk);
        do_reset();

        // Latency and the less-than path.
        step(1'b1, 32'd5, 32'd3, 32'd10, 1'b1, 1'b1, '{32'd30, 32'd15, 32'd30, 32'd15}, acc);
        chk("lat_accept", acc, 1'b1);
        lat = 0;
        do begin
            idle(1'b1);
            lat++;
        end while (!seen_ov && lat < 10);
        chk("latency", lat, 3);
        drain("lat_drain");

        send_known(32'd4, 32'd2, 32'd2, '{32'd6, 32'd1, 32'd6, 32'd1});
        send_known(32'd1, 32'd9, 32'd0, '{32'd10, 32'd10, 32'd10, 32'd10});
        send_known(32'hFFFF_FFFF, 32'd1, 32'd0,
                   '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0});

        // Backpressure: five back-to-back triples against a 6-cycle stall.
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = $urandom; bp_b[i] = $urandom; bp_c[i] = $urandom;
        end
        sent = 0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, bp_a[sent], bp_b[sent], bp_c[sent], 1'b0, 1'b0, '0, acc);
            if (acc) begin
                n_acc++;
                sent++;
            end
        end
        chk("bp_accepts", n_acc, 3);
        chk("bp_in_ready_low", in_ready_u, 1'b0);
        lat = 0;
        while (sent < 5 && lat < 20) begin
            step(1'b1, bp_a[sent], bp_b[sent], bp_c[sent], 1'b1, 1'b0, '0, acc);
            if (acc) sent++;
            lat++;
        end
        chk("bp_all_sent", sent, 5);
        drain("bp_drain");

        // Randomized streaming with a mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                for (int k = 0; k < 4; k++) begin
                    step(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0, '0, acc);
                end
                chk("pre_rst_inflight", q.size(), 3);
                do_reset();
            end
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rc = ($urandom_range(0, 3) == 0) ? rb : $urandom;
            step($urandom_range(0, 9) < 7, ra, rb, rc, $urandom_range(0, 9) < 7,
                 1'b0, '0, acc);
        end
        drain("final_drain");
        for (int i = 0; i < 5; i++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
